result_stream_reader: RTL and testbench
=======================================

// Module: result_stream_reader
// PURPOSE
//   Downstream stage of the 3x3 matrix multiplier. On a start pulse (tied to the
//   multiplier's done), reads the SIZE*SIZE result words from the result memory.
//   The memory has a 1-cycle registered read. Words are emitted in row-major order
//   on a valid/ready stream, tagged with row, column and last.
//   A 2-entry output FIFO absorbs read latency so the block runs at 1 word/clk
//   under arbitrary backpressure.
// PARAMETERS
//   SIZE   3   matrix dimension; SIZE*SIZE words per frame
//   DW     16  result word width
//   AW     4   result memory address width; must hold SIZE*SIZE-1
// PORTS
//   clk        in   1   clock
//   rst        in   1   reset, asynchronous, active-high
//   start      in   1   1-cycle pulse: begin reading one frame
//   busy       out  1   high from start accept until the last word is handshaken
//   frame_done out  1   1-cycle pulse, cycle after the last word's handshake
//   mem_rd_en  out  1   read strobe to result memory (its write_enable held 0)
//   mem_addr   out  AW  read address, row*SIZE+col
//   mem_rdata  in   DW  memory data_out, valid the cycle after mem_rd_en
//   out_valid  out  1   out_data/out_row/out_col/out_last valid
//   out_ready  in   1   consumer accepts when out_valid&out_ready at posedge
//   out_data   out  DW  result element
//   out_row    out  2   element row index i
//   out_col    out  2   element column index j
//   out_last   out  1   high with element SIZE*SIZE-1
// BEHAVIOUR
// - Reset: all outputs 0; FSM=IDLE; FIFO empty; counters and in-flight flag cleared.
// - FSM states:
//   - IDLE: start=1 -> ISSUE.
//   - ISSUE: exits to DRAIN once address SIZE*SIZE-1 has been issued.
//   - DRAIN: exits to IDLE on the last handshake; frame_done pulses next cycle.
// - busy: asserts the cycle after start is sampled; deasserts with IDLE entry.
// - start while busy: ignored; does not restart or extend the frame.
// - Read issue (ISSUE only):
//   - credit = fifo_count + inflight - (out_valid&out_ready).
//   - mem_rd_en=1 iff credit<2; mem_addr = issue counter (0..SIZE*SIZE-1).
//   - Counter increments on each issue; inflight = registered mem_rd_en.
// - Capture: when inflight=1, mem_rdata is pushed into the FIFO at that posedge.
//   The credit rule guarantees the FIFO never overflows.
// - Output:
//   - out_* come from the FIFO head; out_valid = fifo not empty.
//   - Held stable while out_valid&!out_ready.
//   - Pop on handshake; simultaneous push+pop keeps count unchanged.
// - Tags: out_row/out_col are an output-side counter advanced on handshake.
//   - col wraps SIZE-1->0 and increments row; both wrap to 0 after the last word.
//   - out_last = (row==SIZE-1 && col==SIZE-1) && out_valid.
// - Latency: start sampled at edge E0 -> mem_rd_en high after E0 -> out_valid high
//   after E2, i.e. first word available 2 edges after start.
// - Throughput: with out_ready=1, one word per clk; SIZE*SIZE handshakes on
//   consecutive cycles.
// - Backpressure: with out_ready=0, at most 2 reads are outstanding; issue
//   resumes the cycle credit drops.
// - Reset mid-frame: immediate abort; FIFO flushed; no frame_done; next start
//   begins again at address 0.
// - Widths: mem_addr = row*SIZE+col computed in AW bits; data passes
//   unmodified (no arithmetic on DW).
// TESTING
// - Nominal: memory preloaded with A*B = 30,24,18,84,69,54,138,114,90; start,
//   out_ready=1 -> 9 consecutive words in that order, row/col (0,0)..(2,2),
//   out_last only on 90, frame_done 1 cycle later, busy low after.
// - Backpressure: out_ready=0 for 10 cycles after start -> out_valid=1,
//   out_data=30 held stable, only 2 mem_rd_en pulses; release -> remaining 7
//   words, no loss or duplicates.
// - Random out_ready (50%) over 20 frames -> every frame is the 9 words in
//   order, exactly one out_last and one frame_done per frame.
// - start asserted again while busy (at word 4) -> ignored; frame completes
//   with exactly 9 words.
// - rst asserted after 3 handshakes -> all outputs 0 next cycle, no frame_done;
//   a new start emits from 30 at (0,0).
// - Back-to-back: start pulsed the cycle after frame_done -> second frame
//   identical, first word 2 edges after start.

Source files
------------

// File: rtl/result_stream_reader_if.sv
// Bundle between the result reader, the result memory read port and the downstream consumer.
// master = reader side, slave = environment (memory + consumer + start source).
interface result_stream_reader_if #(
  parameter int DW = 16,
  parameter int AW = 4
);
  logic          start;
  logic          busy;
  logic          frame_done;
  logic          mem_rd_en;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_rdata;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic [1:0]    out_row;
  logic [1:0]    out_col;
  logic          out_last;

  modport master (
    input  start, mem_rdata, out_ready,
    output busy, frame_done, mem_rd_en, mem_addr,
           out_valid, out_data, out_row, out_col, out_last
  );

  modport slave (
    output start, mem_rdata, out_ready,
    input  busy, frame_done, mem_rd_en, mem_addr,
           out_valid, out_data, out_row, out_col, out_last
  );
endinterface

// File: rtl/result_stream_reader.sv
// Reads one SIZE*SIZE result frame from a 1-cycle-latency memory and streams it
// row-major on valid/ready, using a 2-entry FIFO and read credits to sustain 1 word/clk.
//   state | meaning
//   IDLE  | waiting for start
//   ISSUE | issuing reads, gated by FIFO credit
//   DRAIN | all reads issued, emptying FIFO until the last handshake
module result_stream_reader #(
  parameter int SIZE = 3,
  parameter int DW   = 16,
  parameter int AW   = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  result_stream_reader_if.master bus_if
);

  localparam int            NWORDS    = SIZE * SIZE;
  localparam logic [AW-1:0] LAST_ADDR = AW'(NWORDS - 1);
  localparam logic [1:0]    LAST_IDX  = 2'(SIZE - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] issue_cnt_q, issue_cnt_d;
  logic          inflight_q;
  logic [DW-1:0] fifo_q [2];
  logic          wr_ptr_q, rd_ptr_q;
  logic [1:0]    count_q;
  logic [1:0]    row_q, col_q;
  logic          frame_done_q;

  logic          out_valid;
  logic          hs;
  logic          last_word;
  logic          rd_en;
  logic [2:0]    occupancy;

  assign out_valid = (count_q != 2'd0);
  assign hs        = out_valid & bus_if.out_ready;
  assign last_word = out_valid && (row_q == LAST_IDX) && (col_q == LAST_IDX);
  assign occupancy = {1'b0, count_q} + {2'b0, inflight_q};
  // A word leaving this cycle frees a slot, so it counts against occupancy.
  assign rd_en     = (state_q == ISSUE) && (occupancy < (3'd2 + {2'b0, hs}));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      issue_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      issue_cnt_q <= issue_cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    issue_cnt_d = issue_cnt_q;
    case (state_q)
      IDLE: begin
        issue_cnt_d = '0;
        if (bus_if.start) state_d = ISSUE;
      end
      ISSUE: begin
        if (rd_en) begin
          issue_cnt_d = issue_cnt_q + AW'(1);
          if (issue_cnt_q == LAST_ADDR) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (hs && last_word) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus_if.busy       = (state_q != IDLE);
    bus_if.frame_done = frame_done_q;
    bus_if.mem_rd_en  = rd_en;
    bus_if.mem_addr   = rd_en ? issue_cnt_q : '0;
    bus_if.out_valid  = out_valid;
    bus_if.out_data   = out_valid ? fifo_q[rd_ptr_q] : '0;
    bus_if.out_row    = row_q;
    bus_if.out_col    = col_q;
    bus_if.out_last   = last_word;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inflight_q   <= 1'b0;
      fifo_q[0]    <= '0;
      fifo_q[1]    <= '0;
      wr_ptr_q     <= 1'b0;
      rd_ptr_q     <= 1'b0;
      count_q      <= 2'd0;
      row_q        <= 2'd0;
      col_q        <= 2'd0;
      frame_done_q <= 1'b0;
    end else begin
      inflight_q   <= rd_en;
      frame_done_q <= (state_q == DRAIN) && hs && last_word;
      if (inflight_q) begin
        fifo_q[wr_ptr_q] <= bus_if.mem_rdata;
        wr_ptr_q         <= ~wr_ptr_q;
      end
      if (hs) rd_ptr_q <= ~rd_ptr_q;
      case ({inflight_q, hs})
        2'b10:   count_q <= count_q + 2'd1;
        2'b01:   count_q <= count_q - 2'd1;
        default: count_q <= count_q;
      endcase
      if (hs) begin
        if (col_q == LAST_IDX) begin
          col_q <= 2'd0;
          row_q <= (row_q == LAST_IDX) ? 2'd0 : row_q + 2'd1;
        end else begin
          col_q <= col_q + 2'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_result_stream_reader.sv
// Directed bench for result_stream_reader: registered memory model, scoreboard of
// expected words pushed per frame, immediate assertions at each comparison.
module tb_result_stream_reader;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  result_stream_reader_if #(.DW(16), .AW(4)) io ();

  result_stream_reader #(.SIZE(3), .DW(16), .AW(4)) dut (
    .clk    (clk),
    .rst    (rst),
    .bus_if (io.master)
  );

  logic [15:0] mem [16];
  logic [15:0] rdata_q;
  always @(posedge clk) if (io.mem_rd_en) rdata_q <= mem[io.mem_addr];
  assign io.mem_rdata = rdata_q;

  typedef struct packed {
    logic [15:0] d;
    logic [1:0]  r;
    logic [1:0]  c;
    logic        l;
  } word_t;

  word_t sb[$];
  logic [15:0] exp_data [9] = '{16'd30, 16'd24, 16'd18, 16'd84, 16'd69,
                                16'd54, 16'd138, 16'd114, 16'd90};

  int n_assert = 0;
  int n_fail   = 0;
  int hs_cnt   = 0;
  int rd_cnt   = 0;
  int fd_cnt   = 0;
  int last_cnt = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Inputs are set at a negedge; handshakes are scored just before the next posedge.
  task automatic tick();
    word_t w;
    #1;
    if (io.out_valid && io.out_ready) begin
      hs_cnt++;
      if (io.out_last) last_cnt++;
      if (sb.size() == 0) check("sb_underflow", 32'(sb.size()), 32'd1);
      else begin
        w = sb.pop_front();
        check("word", {11'b0, io.out_data, io.out_row, io.out_col, io.out_last}, {11'b0, w});
      end
    end
    if (io.mem_rd_en) rd_cnt++;
    @(posedge clk);
    @(negedge clk);
    if (io.frame_done) fd_cnt++;
  endtask

  task automatic push_frame();
    word_t w;
    for (int k = 0; k < 9; k++) begin
      w.d = exp_data[k];
      w.r = 2'(k / 3);
      w.c = 2'(k % 3);
      w.l = (k == 8);
      sb.push_back(w);
    end
  endtask

  task automatic wait_frame(input int budget, input bit rand_ready);
    int n = 0;
    bit seen = 1'b0;
    while (!seen && n < budget) begin
      if (rand_ready) io.out_ready = 1'($urandom_range(0, 1));
      tick();
      n++;
      seen = io.frame_done;
    end
    check("frame_done_seen", 32'(seen), 32'd1);
  endtask

  task automatic run_nominal();
    int hs0, fd0;
    io.out_ready = 1'b1;
    push_frame();
    hs0 = hs_cnt;
    fd0 = fd_cnt;
    io.start = 1'b1;
    tick();
    io.start = 1'b0;
    check("busy_after_start", 32'(io.busy), 32'd1);
    check("rd_en_after_e0", 32'(io.mem_rd_en), 32'd1);
    check("addr_first", 32'(io.mem_addr), 32'd0);
    check("valid_after_e0", 32'(io.out_valid), 32'd0);
    tick();
    check("valid_after_e1", 32'(io.out_valid), 32'd0);
    tick();
    check("valid_after_e2", 32'(io.out_valid), 32'd1);
    check("first_data", 32'(io.out_data), 32'd30);
    for (int i = 0; i < 9; i++) begin
      tick();
      check("consecutive_hs", 32'(hs_cnt - hs0), 32'(i + 1));
    end
    check("frame_done_pulse", 32'(fd_cnt - fd0), 32'd1);
    check("busy_after_frame", 32'(io.busy), 32'd0);
    check("sb_empty_nominal", 32'(sb.size()), 32'd0);
    tick();
    check("frame_done_one_cycle", 32'(io.frame_done), 32'd0);
  endtask

  initial begin
    int hs0, rd0, fd0, ls0, n;
    for (int i = 0; i < 16; i++) mem[i] = 16'hDEAD;
    for (int i = 0; i < 9; i++) mem[i] = exp_data[i];
    rst = 1'b1;
    io.start = 1'b0;
    io.out_ready = 1'b0;
    tick();
    tick();
    check("rst_busy", 32'(io.busy), 32'd0);
    check("rst_frame_done", 32'(io.frame_done), 32'd0);
    check("rst_rd_en", 32'(io.mem_rd_en), 32'd0);
    check("rst_addr", 32'(io.mem_addr), 32'd0);
    check("rst_valid", 32'(io.out_valid), 32'd0);
    check("rst_data", 32'(io.out_data), 32'd0);
    check("rst_row", 32'(io.out_row), 32'd0);
    check("rst_col", 32'(io.out_col), 32'd0);
    check("rst_last", 32'(io.out_last), 32'd0);
    rst = 1'b0;
    tick();

    // Nominal frame at full rate
    run_nominal();

    // Backpressure held for 10 cycles after start
    io.out_ready = 1'b0;
    push_frame();
    rd0 = rd_cnt;
    hs0 = hs_cnt;
    io.start = 1'b1;
    tick();
    io.start = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (i >= 1) begin
        check("bp_valid_held", 32'(io.out_valid), 32'd1);
        check("bp_data_held", 32'(io.out_data), 32'd30);
      end
    end
    check("bp_two_reads", 32'(rd_cnt - rd0), 32'd2);
    io.out_ready = 1'b1;
    wait_frame(100, 1'b0);
    check("bp_nine_words", 32'(hs_cnt - hs0), 32'd9);
    check("bp_sb_empty", 32'(sb.size()), 32'd0);

    // Start while busy is ignored
    push_frame();
    hs0 = hs_cnt;
    fd0 = fd_cnt;
    io.start = 1'b1;
    tick();
    io.start = 1'b0;
    n = 0;
    while (hs_cnt - hs0 < 4 && n < 50) begin tick(); n++; end
    check("sw_reach_word4", 32'(hs_cnt - hs0), 32'd4);
    io.start = 1'b1;
    tick();
    io.start = 1'b0;
    wait_frame(100, 1'b0);
    rd0 = rd_cnt;
    repeat (5) tick();
    check("sw_nine_words", 32'(hs_cnt - hs0), 32'd9);
    check("sw_no_restart", 32'(rd_cnt - rd0), 32'd0);
    check("sw_idle", 32'(io.busy), 32'd0);
    check("sw_one_done", 32'(fd_cnt - fd0), 32'd1);
    check("sw_sb_empty", 32'(sb.size()), 32'd0);

    // Reset after 3 handshakes
    io.out_ready = 1'b1;
    push_frame();
    hs0 = hs_cnt;
    fd0 = fd_cnt;
    io.start = 1'b1;
    tick();
    io.start = 1'b0;
    n = 0;
    while (hs_cnt - hs0 < 3 && n < 50) begin tick(); n++; end
    check("mr_reach_word3", 32'(hs_cnt - hs0), 32'd3);
    rst = 1'b1;
    tick();
    check("mr_busy", 32'(io.busy), 32'd0);
    check("mr_valid", 32'(io.out_valid), 32'd0);
    check("mr_data", 32'(io.out_data), 32'd0);
    check("mr_rd_en", 32'(io.mem_rd_en), 32'd0);
    check("mr_row_col", 32'({io.out_row, io.out_col}), 32'd0);
    check("mr_last", 32'(io.out_last), 32'd0);
    sb.delete();
    rst = 1'b0;
    repeat (3) tick();
    check("mr_no_frame_done", 32'(fd_cnt - fd0), 32'd0);
    run_nominal();

    // Random backpressure over 20 back-to-back frames
    hs0 = hs_cnt;
    fd0 = fd_cnt;
    ls0 = last_cnt;
    for (int f = 0; f < 20; f++) begin
      push_frame();
      io.start = 1'b1;
      io.out_ready = 1'($urandom_range(0, 1));
      tick();
      io.start = 1'b0;
      wait_frame(200, 1'b1);
    end
    check("rnd_words", 32'(hs_cnt - hs0), 32'd180);
    check("rnd_lasts", 32'(last_cnt - ls0), 32'd20);
    check("rnd_dones", 32'(fd_cnt - fd0), 32'd20);
    check("rnd_sb_empty", 32'(sb.size()), 32'd0);

    // Start the cycle after frame_done
    run_nominal();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
